// File: rtl/bcd2bin.sv
// bcd2bin: sequential two-digit BCD to 8-bit binary converter.
// Uses reverse double-dabble. A 16-bit work register holds {tens, ones, bin}.
// Each cycle it shifts right once, then pulls 3 back out of any BCD nibble
// that landed at 8 or above. After eight shifts the low byte holds the value.
// An out-of-range digit is rejected in one cycle with an error completion.
module bcd2bin (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dec_high,
  input  logic [3:0] dec_low,
  input  logic       dec_start,
  output logic       dec_busy,
  output logic       dec_done,
  output logic       dec_err,
  output logic [7:0] dec_bin
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] work_q, work_d;
  logic [2:0]  count_q, count_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  bin_q, bin_d;

  logic [15:0] shifted;
  logic [3:0]  highAdj;
  logic [3:0]  lowAdj;

  // One reverse double-dabble step: shift, then correct each BCD nibble on its own
  always_comb begin
    shifted = work_q >> 1;
    highAdj = shifted[15:12];
    lowAdj  = shifted[11:8];
    if (shifted[15:12] >= 4'd8) begin
      highAdj = shifted[15:12] - 4'd3;
    end
    if (shifted[11:8] >= 4'd8) begin
      lowAdj = shifted[11:8] - 4'd3;
    end
  end

  // State register; reset wins over everything and discards any partial result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= 16'h0000;
      count_q <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      bin_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      bin_q   <= bin_d;
    end
  end

  // Next-state and registered-output logic; dec_done is a single-cycle pulse
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    bin_d   = bin_q;

    case (state_q)
      IDLE: begin
        if (dec_start) begin
          if ((dec_high > 4'd9) || (dec_low > 4'd9)) begin
            err_d  = 1'b1;
            bin_d  = 8'h00;
            done_d = 1'b1;
          end else begin
            work_d  = {dec_high, dec_low, 8'h00};
            count_d = 3'd0;
            busy_d  = 1'b1;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d  = {highAdj, lowAdj, shifted[7:0]};
        count_d = count_q + 3'd1;
        if (count_q == 3'd7) begin
          bin_d   = shifted[7:0];
          err_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign dec_busy = busy_q;
  assign dec_done = done_q;
  assign dec_err  = err_q;
  assign dec_bin  = bin_q;

endmodule

// File: tb/tb_bcd2bin.sv
// Self-checking bench for bcd2bin. Expected {err, bin} pairs are queued when a
// request is driven and popped when the converter reports a completion.
module tb_bcd2bin;

  logic       clk;
  logic       rst;
  logic [3:0] dec_high;
  logic [3:0] dec_low;
  logic       dec_start;
  logic       dec_busy;
  logic       dec_done;
  logic       dec_err;
  logic [7:0] dec_bin;

  int checks = 0;
  int errors = 0;
  logic [8:0] scoreboard[$];

  bcd2bin dut (
    .clk       (clk),
    .rst       (rst),
    .dec_high  (dec_high),
    .dec_low   (dec_low),
    .dec_start (dec_start),
    .dec_busy  (dec_busy),
    .dec_done  (dec_done),
    .dec_err   (dec_err),
    .dec_bin   (dec_bin)
  );

  // Free-running 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges the run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Present one request with a single-cycle start pulse; leaves us #1 after the accept edge
  task automatic applyStimulus(input logic [3:0] h, input logic [3:0] l);
    @(negedge clk);
    dec_high  = h;
    dec_low   = l;
    dec_start = 1'b1;
    @(posedge clk);
    #1;
    dec_start = 1'b0;
  endtask

  // Full valid conversion: check latency, busy length, result and done falling
  task automatic doConversion(input logic [3:0] h, input logic [3:0] l, input string tag);
    logic [8:0] expected;
    int lat;
    int busyCount;
    bit seen;
    scoreboard.push_back({1'b0, 8'(h * 10 + l)});
    applyStimulus(h, l);
    lat = -1;
    busyCount = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (dec_done) begin
        lat = i;
        seen = 1'b1;
        break;
      end
      if (dec_busy) busyCount++;
      @(posedge clk);
      #1;
    end
    expected = scoreboard.pop_front();
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL %s_timeout: dec_done never rose, expected after 8 edges", tag);
    end else begin
      if (lat !== 8) begin
        errors++;
        $display("[TB] FAIL %s_latency: got %0d edges expected 8", tag, lat);
      end
      checks++;
      if (dec_bin !== expected[7:0]) begin
        errors++;
        $display("[TB] FAIL %s_bin: got %h expected %h", tag, dec_bin, expected[7:0]);
      end
      checks++;
      if (dec_err !== expected[8]) begin
        errors++;
        $display("[TB] FAIL %s_err: got %b expected %b", tag, dec_err, expected[8]);
      end
      checks++;
      if (busyCount !== 8 || dec_busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s_busy: got %0d cycles (busy at done %b) expected 8 (0)",
                 tag, busyCount, dec_busy);
      end
      @(posedge clk);
      #1;
      checks++;
      if (dec_done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s_pulse: dec_done %b one cycle after completion, expected 0", tag, dec_done);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    dec_start = 1'b0;
    dec_high = 4'd0;
    dec_low = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({dec_busy, dec_done, dec_err, dec_bin} !== 11'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: got busy=%b done=%b err=%b bin=%h expected all 0",
               dec_busy, dec_done, dec_err, dec_bin);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    doConversion(4'd3, 4'd0, "basic_3_0");
  endtask

  task automatic test_boundaries;
    doConversion(4'd0, 4'd0, "bound_0_0");
    doConversion(4'd9, 4'd9, "bound_9_9");
    doConversion(4'd2, 4'd9, "bound_2_9");
    doConversion(4'd1, 4'd5, "bound_1_5");
  endtask

  task automatic test_sweep;
    for (int h = 0; h < 10; h++) begin
      for (int l = 0; l < 10; l++) begin
        doConversion(4'(h), 4'(l), $sformatf("sweep_%0d_%0d", h, l));
      end
    end
  endtask

  task automatic test_error;
    logic [8:0] expected;
    scoreboard.push_back({1'b1, 8'h00});
    applyStimulus(4'hA, 4'd2);
    expected = scoreboard.pop_front();
    checks++;
    if (dec_done !== 1'b1 || dec_err !== expected[8] || dec_bin !== expected[7:0] || dec_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL error_result: got done=%b err=%b bin=%h busy=%b expected 1 1 00 0",
               dec_done, dec_err, dec_bin, dec_busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dec_done !== 1'b0 || dec_busy !== 1'b0 || dec_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL error_after: got done=%b busy=%b err=%b expected 0 0 1",
               dec_done, dec_busy, dec_err);
    end
    doConversion(4'd4, 4'd2, "error_recover_4_2");
  endtask

  task automatic test_back_to_back_errors;
    logic [8:0] expected;
    scoreboard.push_back({1'b1, 8'h00});
    scoreboard.push_back({1'b1, 8'h00});
    @(negedge clk);
    dec_high = 4'd2;
    dec_low = 4'hF;
    dec_start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) dec_start = 1'b0;
      expected = scoreboard.pop_front();
      checks++;
      if (dec_done !== 1'b1 || dec_err !== expected[8] || dec_bin !== expected[7:0]) begin
        errors++;
        $display("[TB] FAIL b2b_err_%0d: got done=%b err=%b bin=%h expected 1 1 00",
                 i, dec_done, dec_err, dec_bin);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (dec_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_err_end: got done=%b expected 0", dec_done);
    end
  endtask

  task automatic test_back_to_back;
    logic [8:0] expected;
    int lat;
    scoreboard.push_back({1'b0, 8'h39});
    scoreboard.push_back({1'b0, 8'h0B});
    @(negedge clk);
    dec_high = 4'd5;
    dec_low = 4'd7;
    dec_start = 1'b1;
    @(posedge clk);
    #1;
    dec_high = 4'd1;
    dec_low = 4'd1;
    for (int pass = 0; pass < 2; pass++) begin
      lat = -1;
      for (int i = 0; i < 20; i++) begin
        if (dec_done) begin
          lat = i;
          break;
        end
        @(posedge clk);
        #1;
      end
      expected = scoreboard.pop_front();
      checks++;
      if (lat !== 8 || dec_bin !== expected[7:0] || dec_err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL b2b_result_%0d: got lat=%0d bin=%h err=%b expected lat=8 bin=%h err=0",
                 pass, lat, dec_bin, dec_err, expected[7:0]);
      end
      @(posedge clk);
      #1;
      if (pass == 0) begin
        dec_start = 1'b0;
        checks++;
        if (dec_busy !== 1'b1 || dec_done !== 1'b0) begin
          errors++;
          $display("[TB] FAIL b2b_restart: got busy=%b done=%b expected 1 0", dec_busy, dec_done);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int doneCount;
    applyStimulus(4'd9, 4'd9);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({dec_busy, dec_done, dec_err, dec_bin} !== 11'd0) begin
      errors++;
      $display("[TB] FAIL midreset_state: got busy=%b done=%b err=%b bin=%h expected all 0",
               dec_busy, dec_done, dec_err, dec_bin);
    end
    doneCount = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (dec_done || dec_busy) doneCount++;
    end
    checks++;
    if (doneCount !== 0) begin
      errors++;
      $display("[TB] FAIL midreset_quiet: got %0d active cycles expected 0", doneCount);
    end
    doConversion(4'd6, 4'd4, "midreset_6_4");
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset;
    test_basic;
    test_boundaries;
    test_error;
    test_back_to_back_errors;
    test_back_to_back;
    test_reset_mid;
    test_sweep;
    checks++;
    if (scoreboard.size() !== 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", scoreboard.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
